i2s_mc_xcvr: RTL and testbench

Parametrised multi-channel I2S / left-justified audio transceiver for the pedal datapath. It generates the codec bit clock (`sclk`) and frame clock (`lrck`) from `mclk`, deserialises `sdi` into a per-frame parallel sample vector, and serialises a parallel vector onto `sdo`. It supports configurable data/slot width, channel count and frame format, and adds transmit-underrun reporting. It sits between the PMOD pins and the effects pipe, replacing the fixed stereo 24-bit transceiver.

---
 rtl/sample_pkg.sv | 20 ++
 rtl/i2s_mc_xcvr_clk_gen.sv | 84 ++++++++
 rtl/i2s_mc_xcvr.sv | 150 +++++++++++++++
 tb/tb_i2s_mc_xcvr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared audio-interface types for the pedal datapath: frame format selector
// and the frame-clock level rule used by the I2S clock generator.
package sample_pkg;

  typedef enum logic {I2S_FMT, LJ_FMT} i2s_fmt_e;

  localparam int MAX_CH = 8;

  // I2S drives lrck one bit early, so it looks at the following bit index.
  function automatic logic lrck_level(input i2s_fmt_e fmt, input int b, input int frame);
    int pos;
    if (fmt == I2S_FMT) begin
      pos = (b + 1 == frame) ? 0 : b + 1;
    end else begin
      pos = b;
    end
    return (pos >= frame / 2);
  endfunction

endpackage

// File: rtl/i2s_mc_xcvr_clk_gen.sv
// Bit/frame clock generator: mclk divider, bit counter, slot/position
// counters, registered sclk/lrck and the fall/rise/frame-start strobes.
module i2s_clk_gen
  import sample_pkg::*;
#(
  parameter int       SLOT_W        = 32,
  parameter int       NUM_CH        = 2,
  parameter int       MCLK_PER_SCLK = 4,
  parameter i2s_fmt_e FMT           = I2S_FMT,
  localparam int      FRAME         = NUM_CH * SLOT_W,
  localparam int      BW            = $clog2(FRAME),
  localparam int      SW            = $clog2(NUM_CH),
  localparam int      KW            = $clog2(SLOT_W)
) (
  input  logic          mclk_i,
  input  logic          rst_n_i,
  output logic          sclk_o,
  output logic          lrck_o,
  output logic          fall_o,
  output logic          rise_o,
  output logic          frame_start_o,
  output logic [SW-1:0] slot_o,
  output logic [KW-1:0] pos_o
);

  localparam int HALF = MCLK_PER_SCLK / 2;
  localparam int DW   = $clog2(MCLK_PER_SCLK);

  logic [DW-1:0] d_q, d_d;
  logic [BW-1:0] b_q, b_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic          sclk_q, sclk_d;
  logic          lrck_q, lrck_d;
  logic          bit_end;

  // b, slot and position all step together on the last mclk of an sclk
  // period, so they hold steady from one fall event to the next.
  always_comb begin
    bit_end = (d_q == DW'(MCLK_PER_SCLK - 1));
    d_d     = bit_end ? '0 : d_q + DW'(1);
    b_d     = b_q;
    s_d     = s_q;
    k_d     = k_q;
    if (bit_end) begin
      b_d = (b_q == BW'(FRAME - 1)) ? '0 : b_q + BW'(1);
      if (k_q == KW'(SLOT_W - 1)) begin
        k_d = '0;
        s_d = (s_q == SW'(NUM_CH - 1)) ? '0 : s_q + SW'(1);
      end else begin
        k_d = k_q + KW'(1);
      end
    end
    sclk_d = (d_d >= DW'(HALF));
    lrck_d = lrck_level(FMT, int'(b_d), FRAME);
  end

  always_ff @(posedge mclk_i) begin
    if (!rst_n_i) begin
      d_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      k_q    <= '0;
      sclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      b_q    <= b_d;
      s_q    <= s_d;
      k_q    <= k_d;
      sclk_q <= sclk_d;
      lrck_q <= lrck_d;
    end
  end

  assign sclk_o        = sclk_q;
  assign lrck_o        = lrck_q;
  assign fall_o        = (d_q == '0);
  assign rise_o        = (d_q == DW'(HALF));
  assign frame_start_o = fall_o && (b_q == '0);
  assign slot_o        = s_q;
  assign pos_o         = k_q;

endmodule

// File: rtl/i2s_mc_xcvr.sv
// Multi-channel I2S / left-justified transceiver: TX holding register and
// frame shifter, RX deserialiser, underrun and frame-valid flags.
module i2s_mc_xcvr
  import sample_pkg::*;
#(
  parameter int       DATA_W        = 24,
  parameter int       SLOT_W        = 32,
  parameter int       NUM_CH        = 2,
  parameter int       MCLK_PER_SCLK = 4,
  parameter i2s_fmt_e FMT           = I2S_FMT
) (
  input  logic                     mclk,
  input  logic                     rst_n,
  output logic [NUM_CH*DATA_W-1:0] rx_data,
  output logic                     rx_vld,
  input  logic [NUM_CH*DATA_W-1:0] tx_data,
  input  logic                     tx_vld,
  output logic                     tx_urun,
  output logic                     lrck,
  output logic                     sclk,
  output logic                     sdo,
  input  logic                     sdi
);

  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int SW      = $clog2(NUM_CH);
  localparam int KW      = $clog2(SLOT_W);
  localparam int CW      = $clog2(DATA_W);
  localparam int IW      = $clog2(FRAME_W);

  typedef logic [FRAME_W-1:0] frame_t;

  if (DATA_W < 2 || DATA_W > SLOT_W) begin : g_bad_data_w
    $error("i2s_mc_xcvr: DATA_W must be in 2..SLOT_W");
  end
  if (NUM_CH < 2 || NUM_CH > MAX_CH || (NUM_CH % 2) != 0) begin : g_bad_num_ch
    $error("i2s_mc_xcvr: NUM_CH must be even and in 2..8");
  end
  if (MCLK_PER_SCLK < 2 || (MCLK_PER_SCLK % 2) != 0) begin : g_bad_div
    $error("i2s_mc_xcvr: MCLK_PER_SCLK must be even and >= 2");
  end

  logic          fall, rise, frame_start;
  logic [SW-1:0] slot;
  logic [KW-1:0] pos;

  i2s_clk_gen #(
    .SLOT_W        (SLOT_W),
    .NUM_CH        (NUM_CH),
    .MCLK_PER_SCLK (MCLK_PER_SCLK),
    .FMT           (FMT)
  ) u_clk_gen (
    .mclk_i        (mclk),
    .rst_n_i       (rst_n),
    .sclk_o        (sclk),
    .lrck_o        (lrck),
    .fall_o        (fall),
    .rise_o        (rise),
    .frame_start_o (frame_start),
    .slot_o        (slot),
    .pos_o         (pos)
  );

  frame_t hold_q, hold_d;
  frame_t tx_frame_q, tx_frame_d;
  frame_t rx_sh_q, rx_sh_d;
  frame_t rx_data_q, rx_data_d;
  frame_t tx_src;
  logic   hold_ok_q, hold_ok_d;
  logic   sdo_q, sdo_d;
  logic   tx_urun_q, tx_urun_d;
  logic   rx_vld_q, rx_vld_d;
  logic   sdi_q;

  logic [DATA_W-1:0] tx_ch;
  logic [DATA_W-2:0] rx_ch;
  int                slot_n, pos_n;

  // The frame load is evaluated before the tx_vld write so a same-cycle
  // write only affects the following frame.
  always_comb begin
    slot_n     = int'(slot);
    pos_n      = int'(pos);
    hold_d     = hold_q;
    hold_ok_d  = hold_ok_q;
    tx_frame_d = tx_frame_q;
    sdo_d      = sdo_q;
    tx_urun_d  = 1'b0;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_vld_d   = 1'b0;
    tx_src     = tx_frame_q;

    if (frame_start) begin
      tx_src     = hold_ok_q ? hold_q : '0;
      tx_frame_d = tx_src;
      tx_urun_d  = !hold_ok_q;
      hold_ok_d  = 1'b0;
    end
    if (tx_vld) begin
      hold_d    = tx_data;
      hold_ok_d = 1'b1;
    end

    tx_ch = tx_src[IW'(slot_n * DATA_W) +: DATA_W];
    if (fall) begin
      sdo_d = (pos_n < DATA_W) ? tx_ch[CW'(DATA_W - 1 - pos_n)] : 1'b0;
    end

    // Completing the last data bit of the last slot publishes the frame.
    rx_ch = rx_sh_q[IW'(slot_n * DATA_W) +: (DATA_W - 1)];
    if (rise && pos_n < DATA_W) begin
      rx_sh_d[IW'(slot_n * DATA_W) +: DATA_W] = {rx_ch, sdi_q};
      if (slot_n == NUM_CH - 1 && pos_n == DATA_W - 1) begin
        rx_data_d = rx_sh_d;
        rx_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_ok_q  <= 1'b0;
      tx_frame_q <= '0;
      sdo_q      <= 1'b0;
      tx_urun_q  <= 1'b0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      sdi_q      <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_ok_q  <= hold_ok_d;
      tx_frame_q <= tx_frame_d;
      sdo_q      <= sdo_d;
      tx_urun_q  <= tx_urun_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      sdi_q      <= sdi;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign tx_urun = tx_urun_q;
  assign sdo     = sdo_q;

endmodule

// File: tb/tb_i2s_mc_xcvr.sv
// Loopback bench for i2s_mc_xcvr: a default I2S stereo instance and an LJ
// 4-channel instance, checked through event scoreboards plus directed probes.
module tb_i2s_mc_xcvr;
  import sample_pkg::*;

  typedef struct {
    int          at;
    logic [95:0] data;
  } expEv_t;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        rstN;
  logic [47:0] rxDataA, txDataA;
  logic        rxVldA, txVldA, txUrunA, lrckA, sclkA, sdoA, sdiA;
  logic [95:0] rxDataB, txDataB;
  logic        rxVldB, txVldB, txUrunB, lrckB, sclkB, sdoB, sdiB;

  assign sdiA = sdoA;
  assign sdiB = sdoB;

  i2s_mc_xcvr dutA (
    .mclk(mclk), .rst_n(rstN), .rx_data(rxDataA), .rx_vld(rxVldA),
    .tx_data(txDataA), .tx_vld(txVldA), .tx_urun(txUrunA),
    .lrck(lrckA), .sclk(sclkA), .sdo(sdoA), .sdi(sdiA)
  );

  i2s_mc_xcvr #(
    .DATA_W(24), .SLOT_W(24), .NUM_CH(4), .MCLK_PER_SCLK(4), .FMT(LJ_FMT)
  ) dutB (
    .mclk(mclk), .rst_n(rstN), .rx_data(rxDataB), .rx_vld(rxVldB),
    .tx_data(txDataB), .tx_vld(txVldB), .tx_urun(txUrunB),
    .lrck(lrckB), .sclk(sclkB), .sdo(sdoB), .sdi(sdiB)
  );

  int     errors = 0;
  int     checks = 0;
  int     cyc    = -1;
  int     phase  = 0;
  logic   sdoOr0 = 1'b0;
  logic   sdoOr4 = 1'b0;
  expEv_t qRxA[$];
  expEv_t qRxB[$];
  int     qUrA[$];
  int     qUrB[$];
  expEv_t evA, evB;
  int     urA, urB;

  logic [47:0] v1, v2, v3, v4;
  logic [95:0] w;

  // Index of the most recent mclk edge since reset release; -1 while in reset.
  always @(posedge mclk) cyc <= rstN ? cyc + 1 : -1;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reportSpurious(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: unexpected pulse at cycle %0d", name, cyc);
  endtask

  task automatic applyStimulus(input int inst, input logic [95:0] data);
    if (inst == 0) begin
      txDataA = data[47:0];
      txVldA  = 1'b1;
    end else begin
      txDataB = data;
      txVldB  = 1'b1;
    end
    @(negedge mclk);
    txVldA = 1'b0;
    txVldB = 1'b0;
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) @(negedge mclk);
  endtask

  task automatic pushRx(input int inst, input int at, input logic [95:0] data);
    expEv_t e;
    e.at   = at;
    e.data = data;
    if (inst == 0) qRxA.push_back(e);
    else qRxB.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sclkA"}, 96'(sclkA), 96'(0));
    checkOutput({tag, "_lrckA"}, 96'(lrckA), 96'(0));
    checkOutput({tag, "_sdoA"}, 96'(sdoA), 96'(0));
    checkOutput({tag, "_rxVldA"}, 96'(rxVldA), 96'(0));
    checkOutput({tag, "_urunA"}, 96'(txUrunA), 96'(0));
    checkOutput({tag, "_rxDataA"}, 96'(rxDataA), 96'(0));
    checkOutput({tag, "_sclkB"}, 96'(sclkB), 96'(0));
    checkOutput({tag, "_lrckB"}, 96'(lrckB), 96'(0));
    checkOutput({tag, "_sdoB"}, 96'(sdoB), 96'(0));
    checkOutput({tag, "_rxVldB"}, 96'(rxVldB), 96'(0));
    checkOutput({tag, "_urunB"}, 96'(txUrunB), 96'(0));
    checkOutput({tag, "_rxDataB"}, rxDataB, 96'(0));
  endtask

  // Scoreboard monitor: every pulse must match the next expected event.
  always @(negedge mclk) begin
    if (rxVldA === 1'b1) begin
      if (qRxA.size() == 0) reportSpurious("rxA_vld");
      else begin
        evA = qRxA.pop_front();
        checkOutput("rxA_cycle", 96'(cyc), 96'(evA.at));
        checkOutput("rxA_data", 96'(rxDataA), evA.data);
      end
    end
    if (rxVldB === 1'b1) begin
      if (qRxB.size() == 0) reportSpurious("rxB_vld");
      else begin
        evB = qRxB.pop_front();
        checkOutput("rxB_cycle", 96'(cyc), 96'(evB.at));
        checkOutput("rxB_data", rxDataB, evB.data);
      end
    end
    if (txUrunA === 1'b1) begin
      if (qUrA.size() == 0) reportSpurious("urunA");
      else begin
        urA = qUrA.pop_front();
        checkOutput("urunA_cycle", 96'(cyc), 96'(urA));
      end
    end
    if (txUrunB === 1'b1) begin
      if (qUrB.size() == 0) reportSpurious("urunB");
      else begin
        urB = qUrB.pop_front();
        checkOutput("urunB_cycle", 96'(cyc), 96'(urB));
      end
    end
  end

  // Collect sdo over the two frames that must carry only zeros.
  always @(negedge mclk) begin
    if (phase == 1 && cyc >= 0 && cyc <= 255) sdoOr0 = sdoOr0 | sdoA;
    if (phase == 1 && cyc >= 1024 && cyc <= 1279) sdoOr4 = sdoOr4 | sdoA;
  end

  initial begin
    v1 = {24'h800001, 24'h7FFFFE};
    v2 = {24'h123456, 24'hABCDEF};
    v3 = {24'h00FF00, 24'hFF00FF};
    v4 = {24'hA5A5A5, 24'h5A5A5A};
    w  = {24'h00000F, 24'h800000, 24'h123456, 24'hC0FFEE};
    rstN    = 1'b0;
    txVldA  = 1'b0;
    txDataA = '0;
    txVldB  = 1'b0;
    txDataB = '0;

    repeat (4) @(negedge mclk);
    checkAllZero("reset");

    qUrA.push_back(0);
    qUrA.push_back(1024);
    qUrA.push_back(1536);
    pushRx(0, 222, 96'(0));
    pushRx(0, 478, 96'(v1));
    pushRx(0, 734, 96'(v2));
    pushRx(0, 990, 96'(v3));
    pushRx(0, 1246, 96'(0));
    pushRx(0, 1502, 96'(v4));
    qUrB.push_back(0);
    qUrB.push_back(768);
    qUrB.push_back(1152);
    qUrB.push_back(1536);
    pushRx(1, 382, 96'(0));
    pushRx(1, 766, w);
    pushRx(1, 1150, 96'(0));
    pushRx(1, 1534, 96'(0));
    phase = 1;
    rstN  = 1'b1;

    for (int i = 0; i < 8; i++) begin
      waitCyc(i);
      checkOutput($sformatf("sclkA_%0d", i), 96'(sclkA), 96'((i % 4 == 1) || (i % 4 == 2)));
    end
    waitCyc(10);
    applyStimulus(1, w);
    waitCyc(50);
    applyStimulus(0, 96'(v1));
    waitCyc(122);
    checkOutput("lrckA_b30", 96'(lrckA), 96'(0));
    waitCyc(123);
    checkOutput("lrckA_b31", 96'(lrckA), 96'(1));
    waitCyc(190);
    checkOutput("lrckB_b47", 96'(lrckB), 96'(0));
    waitCyc(191);
    checkOutput("lrckB_b48", 96'(lrckB), 96'(1));
    waitCyc(250);
    checkOutput("lrckA_b62", 96'(lrckA), 96'(1));
    waitCyc(251);
    checkOutput("lrckA_b63", 96'(lrckA), 96'(0));
    waitCyc(256);
    checkOutput("sdoA_frame0_zero", 96'(sdoOr0), 96'(0));
    checkOutput("sdoA_f1_ch0_msb", 96'(sdoA), 96'(v1[23]));
    waitCyc(300);
    applyStimulus(0, 96'(v2));
    waitCyc(378);
    checkOutput("lrckA_f1_b30", 96'(lrckA), 96'(0));
    waitCyc(379);
    checkOutput("lrckA_f1_b31", 96'(lrckA), 96'(1));
    waitCyc(382);
    checkOutput("lrckB_b95", 96'(lrckB), 96'(1));
    waitCyc(383);
    checkOutput("lrckB_f1_b0", 96'(lrckB), 96'(0));
    waitCyc(384);
    checkOutput("sdoB_f1_ch0_msb", 96'(sdoB), 96'(w[23]));
    checkOutput("sdoA_f1_ch1_msb", 96'(sdoA), 96'(v1[47]));
    waitCyc(511);
    applyStimulus(0, 96'(v3));
    waitCyc(600);
    checkOutput("rxDataA_hold", 96'(rxDataA), 96'(v1));
    waitCyc(1100);
    applyStimulus(0, 96'(v4));
    waitCyc(1280);
    checkOutput("sdoA_frame4_zero", 96'(sdoOr4), 96'(0));

    waitCyc(1696);
    rstN = 1'b0;
    @(negedge mclk);
    checkAllZero("midreset");
    qUrA.push_back(0);
    qUrA.push_back(256);
    pushRx(0, 222, 96'(0));
    qUrB.push_back(0);
    qUrB.push_back(384);
    pushRx(1, 382, 96'(0));
    phase = 2;
    rstN  = 1'b1;

    waitCyc(122);
    checkOutput("restart_lrckA_b30", 96'(lrckA), 96'(0));
    waitCyc(123);
    checkOutput("restart_lrckA_b31", 96'(lrckA), 96'(1));
    waitCyc(450);

    checkOutput("drain_rxA", 96'(qRxA.size()), 96'(0));
    checkOutput("drain_rxB", 96'(qRxB.size()), 96'(0));
    checkOutput("drain_urA", 96'(qUrA.size()), 96'(0));
    checkOutput("drain_urB", 96'(qUrB.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
